// File: rtl/boot_mem_if.sv
// Memory and loader bus between the rv32 core / byte loader and boot_mem.
// The core-side word port and the byte-serial loader handshake share one bundle.
interface boot_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;

  // Driver side: the core memory port plus the loader byte source
  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr, ld_valid, ld_byte,
    input  mem_rdata, ld_ready
  );

  // The RAM and loader
  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr, ld_valid, ld_byte,
    output mem_rdata, ld_ready
  );
endinterface

// File: rtl/boot_mem.sv
// Word-addressed boot RAM with a byte-serial program loader.
// After reset the loader takes a 16-bit little-endian word count followed by
// that many little-endian 32-bit words, then releases the core from reset and
// serves its single memory port with one cycle of registered read latency.
module boot_mem #(
  parameter int DEPTH     = 256,
  parameter int AW        = $clog2(DEPTH),
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  boot_mem_if.slave  bus,
  output logic       core_reset,
  output logic       load_done,
  output logic       load_err
);

  typedef enum logic [1:0] {HDR0, HDR1, DATA, RUN} state_t;

  // A loader with BOOT_LOAD=0 starts straight in RUN
  localparam state_t START_STATE = BOOT_LOAD ? HDR0 : RUN;

  state_t      state, state_next;
  logic [15:0] len, len_next;
  logic [15:0] wcnt, wcnt_next;
  logic [1:0]  bcnt, bcnt_next;
  logic [23:0] asm_word, asm_next;
  logic        err_next;

  logic          fire;
  logic          addr_ok;
  logic [AW-1:0] core_idx;
  logic [15:0]   hdr_len;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          rd_en;

  // RAM contents are deliberately not reset so a reset mid-load keeps written words
  logic [31:0] ram [DEPTH];

  assign bus.ld_ready = (state != RUN);
  assign fire         = bus.ld_valid & bus.ld_ready;
  assign addr_ok      = (bus.mem_addr[31:AW] == '0);
  assign core_idx     = bus.mem_addr[AW-1:0];
  assign hdr_len      = {bus.ld_byte, len[7:0]};
  // A simultaneous write wins; the read is suppressed so mem_rdata holds
  assign rd_en        = (state == RUN) && bus.mem_rd && !bus.mem_wr;

  // Loader FSM and datapath state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= START_STATE;
      len      <= '0;
      wcnt     <= '0;
      bcnt     <= '0;
      asm_word <= '0;
      load_err <= 1'b0;
    end else begin
      state    <= state_next;
      len      <= len_next;
      wcnt     <= wcnt_next;
      bcnt     <= bcnt_next;
      asm_word <= asm_next;
      load_err <= err_next;
    end
  end

  // Next-state logic and the single RAM write port shared by loader and core
  always_comb begin
    state_next = state;
    len_next   = len;
    wcnt_next  = wcnt;
    bcnt_next  = bcnt;
    asm_next   = asm_word;
    err_next   = load_err;
    wr_en      = 1'b0;
    wr_addr    = core_idx;
    wr_data    = bus.mem_wdata;

    case (state)
      HDR0: begin
        if (fire) begin
          len_next[7:0] = bus.ld_byte;
          state_next    = HDR1;
        end
      end

      HDR1: begin
        if (fire) begin
          len_next[15:8] = bus.ld_byte;
          if ({1'b0, hdr_len} > 17'(DEPTH)) begin
            err_next = 1'b1;
          end
          if (hdr_len == 16'd0) begin
            state_next = RUN;
          end else begin
            state_next = DATA;
            wcnt_next  = '0;
            bcnt_next  = '0;
          end
        end
      end

      DATA: begin
        if (fire) begin
          bcnt_next = bcnt + 2'd1;
          case (bcnt)
            2'd0: asm_next[7:0]   = bus.ld_byte;
            2'd1: asm_next[15:8]  = bus.ld_byte;
            2'd2: asm_next[23:16] = bus.ld_byte;
            default: begin
              // Fourth byte completes the word; words past the end are dropped
              wr_data   = {bus.ld_byte, asm_word};
              wr_addr   = wcnt[AW-1:0];
              wr_en     = ({1'b0, wcnt} < 17'(DEPTH));
              wcnt_next = wcnt + 16'd1;
              if (wcnt == len - 16'd1) begin
                state_next = RUN;
              end
            end
          endcase
        end
      end

      default: begin
        // RUN: serve core stores; out-of-range stores are dropped
        wr_en = bus.mem_wr && addr_ok;
      end
    endcase
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end

  // Registered read; value holds until the next serviced read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_rdata <= '0;
    end else if (rd_en) begin
      bus.mem_rdata <= addr_ok ? ram[core_idx] : 32'h0;
    end
  end

  // Core release and load-complete flags follow RUN by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_reset <= 1'b1;
      load_done  <= 1'b0;
    end else if (state == RUN) begin
      core_reset <= 1'b0;
      load_done  <= 1'b1;
    end
  end

endmodule
